// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C target
package i2c_pkg;
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
   } state_t;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ = 1'b1;
   localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;
endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronises SCL/SDA and flags clock edges, START and STOP
module i2c_bus_monitor #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_s, scl_prev, sda_prev;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev;
   assign scl_fall = ~scl_s & scl_prev;
   assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_det = scl_s & scl_prev & ~sda_prev & sda_s;
endmodule

// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: I2C target with an auto-incrementing register bank
module i2c_slave_regbank
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
   parameter int DATA_W = 8,
   parameter int DEPTH = 16,
   parameter int PTR_W = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              busy,
   output logic              wr_stb,
   output logic [PTR_W-1:0]  wr_ptr,
   output logic              done,
   output logic              ack_err,
   input  logic [PTR_W-1:0]  host_ptr,
   output logic [DATA_W-1:0] host_rdata
);
   state_t state, state_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [DATA_W-1:0] shreg, shreg_n, byte_in, rdata;
   logic [PTR_W-1:0] ptr, ptr_n, wr_ptr_n;
   logic rw, rw_n, matched, matched_n, ackd, ackd_n, we;
   logic sda_oe_n, busy_n, wr_stb_n, done_n, ack_err_n;
   logic scl_rise, scl_fall, start_det, stop_det, sda_s;
   logic [DATA_W-1:0] mem [DEPTH];

   i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
      .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
      .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
      .stop_det(stop_det), .sda_s(sda_s)
   );

   assign byte_in = {shreg[DATA_W-2:0], sda_s};
   assign rdata = mem[ptr];
   assign host_rdata = mem[host_ptr];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         bit_cnt <= '0;
         shreg <= '0;
         ptr <= '0;
         rw <= 1'b0;
         matched <= 1'b0;
         ackd <= 1'b0;
         sda_oe <= 1'b0;
         busy <= 1'b0;
         wr_stb <= 1'b0;
         wr_ptr <= '0;
         done <= 1'b0;
         ack_err <= 1'b0;
      end else begin
         state <= state_n;
         bit_cnt <= bit_cnt_n;
         shreg <= shreg_n;
         ptr <= ptr_n;
         rw <= rw_n;
         matched <= matched_n;
         ackd <= ackd_n;
         sda_oe <= sda_oe_n;
         busy <= busy_n;
         wr_stb <= wr_stb_n;
         wr_ptr <= wr_ptr_n;
         done <= done_n;
         ack_err <= ack_err_n;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
      else if (we) mem[ptr] <= byte_in;

   always_comb begin
      state_n = state;
      bit_cnt_n = bit_cnt;
      shreg_n = shreg;
      ptr_n = ptr;
      rw_n = rw;
      matched_n = matched;
      ackd_n = ackd;
      sda_oe_n = sda_oe;
      busy_n = busy;
      wr_stb_n = 1'b0;
      wr_ptr_n = wr_ptr;
      done_n = 1'b0;
      ack_err_n = ack_err;
      we = 1'b0;
      if (stop_det) begin
         state_n = IDLE;
         sda_oe_n = 1'b0;
         busy_n = 1'b0;
         done_n = matched;
         matched_n = 1'b0;
         ack_err_n = ack_err | (state == RDATA) | (state == RACK && ackd);
      end else if (start_det) begin
         state_n = ADDR;
         bit_cnt_n = '0;
         sda_oe_n = 1'b0;
         ack_err_n = 1'b0;
         busy_n = 1'b1;
         matched_n = 1'b0;
         ackd_n = 1'b0;
      end else
         case (state)
            ADDR, PTR, WDATA: if (scl_rise) begin
               shreg_n = byte_in;
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (state == ADDR) begin
                     matched_n = byte_in[DATA_W-1:1] == SLAVE_ADDR;
                     rw_n = byte_in[0];
                     state_n = matched_n ? ADDR_ACK : WAIT_STOP;
                  end else if (state == PTR) begin
                     ptr_n = byte_in[PTR_W-1:0];
                     state_n = PTR_ACK;
                  end else begin
                     we = 1'b1;
                     wr_stb_n = 1'b1;
                     wr_ptr_n = ptr;
                     ptr_n = ptr + PTR_W'(1);
                     state_n = WDATA_ACK;
                  end
               end
            end
            // first fall after the byte starts the ACK pulse, the second ends it
            ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
               sda_oe_n = ~sda_oe;
               bit_cnt_n = '0;
               if (sda_oe) begin
                  if (state == ADDR_ACK && rw == RW_READ) begin
                     state_n = RDATA;
                     shreg_n = rdata;
                     sda_oe_n = ~rdata[DATA_W-1];
                  end else state_n = (state == ADDR_ACK) ? PTR : WDATA;
               end
            end
            RDATA: if (scl_fall) begin
               bit_cnt_n = bit_cnt + 3'd1;
               shreg_n = shreg << 1;
               sda_oe_n = (bit_cnt != 3'd7) & ~shreg[DATA_W-2];
               if (bit_cnt == 3'd7) state_n = RACK;
            end
            RACK: if (scl_rise) begin
               ptr_n = ptr + PTR_W'(1);
               ackd_n = ~sda_s;
               state_n = sda_s ? WAIT_STOP : RACK;
            end else if (scl_fall && ackd) begin
               state_n = RDATA;
               ackd_n = 1'b0;
               bit_cnt_n = '0;
               shreg_n = rdata;
               sda_oe_n = ~rdata[DATA_W-1];
            end
            default: ;
         endcase
   end
endmodule

// File: tb/tb_i2c_slave_regbank.sv
// tb_i2c_slave_regbank: directed I2C master transactions against the register bank
module tb_i2c_slave_regbank;
   import i2c_pkg::*;
   localparam int Q = 8;
   logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
   logic sda_oe, busy, wr_stb, done, ack_err, sda_line;
   logic [3:0] wr_ptr, host_ptr = '0;
   logic [7:0] host_rdata;
   int vecs = 0, errs = 0, stb_cnt = 0, done_cnt = 0, oe_cnt = 0;
   logic [3:0] stb_log [64];

   assign sda_line = sda_m & ~sda_oe;
   always #5 clk = ~clk;

   i2c_slave_regbank dut (
      .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
      .busy(busy), .wr_stb(wr_stb), .wr_ptr(wr_ptr), .done(done), .ack_err(ack_err),
      .host_ptr(host_ptr), .host_rdata(host_rdata)
   );

   always @(negedge clk) begin
      if (wr_stb) begin
         stb_log[stb_cnt % 64] = wr_ptr;
         stb_cnt++;
      end
      if (done) done_cnt++;
      if (sda_oe) oe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_mem(input int idx, input logic [7:0] exp);
      host_ptr = 4'(idx);
      #1 check($sformatf("mem[%0d]", idx), host_rdata, exp);
   endtask

   task automatic wait_q;
      repeat (Q) @(negedge clk);
   endtask

   task automatic start_cond;
      sda_m = 1'b1; wait_q; scl = 1'b1; wait_q; sda_m = 1'b0; wait_q; scl = 1'b0; wait_q;
   endtask

   task automatic stop_cond;
      sda_m = 1'b0; wait_q; scl = 1'b1; wait_q; sda_m = 1'b1; wait_q;
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; wait_q; scl = 1'b1; wait_q; wait_q; scl = 1'b0; wait_q;
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_q; scl = 1'b1; wait_q; b = sda_line; wait_q; scl = 1'b0; wait_q;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit lat, output logic ack);
      for (int i = 7; i > 0; i--) send_bit(b[i]);
      sda_m = b[0]; wait_q; scl = 1'b1; wait_q; wait_q; scl = 1'b0;
      @(negedge clk); @(negedge clk);
      if (lat) check("ack_lat_early", sda_oe, 0);
      @(negedge clk);
      if (lat) check("ack_lat", sda_oe, 1);
      repeat (Q - 3) @(negedge clk);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         d = {d[6:0], b};
      end
      send_bit(ack);
   endtask

   initial begin
      int s0, d0, o0;
      logic a;
      logic [7:0] d;
      logic [7:0] wd [3] = '{8'h11, 8'h22, 8'h33};
      logic [7:0] rd [3] = '{8'h0E, 8'h0F, 8'h00};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_stb", wr_stb, 0);
      check("rst_done", done, 0);
      check("rst_ack_err", ack_err, 0);
      check_mem(7, 8'h07);
      check_mem(15, 8'h0F);
      // START detection latency
      sda_m = 1'b0;
      @(negedge clk); @(negedge clk);
      check("lat_busy_early", busy, 0);
      @(negedge clk);
      check("lat_busy", busy, 1);
      wait_q; scl = 1'b0; wait_q;
      stop_cond;
      check("lat_busy_clr", busy, 0);
      // write burst
      s0 = stb_cnt; d0 = done_cnt;
      start_cond;
      send_byte(8'hA0, 1'b1, a); check("wr_addr_ack", a, 0);
      send_byte(8'h03, 1'b0, a); check("wr_ptr_ack", a, 0);
      for (int i = 0; i < 3; i++) begin
         send_byte(wd[i], 1'b0, a);
         check($sformatf("wr_data%0d_ack", i), a, 0);
      end
      check("wr_busy", busy, 1);
      stop_cond;
      check("wr_busy_clr", busy, 0);
      check("wr_stb_count", stb_cnt - s0, 3);
      for (int i = 0; i < 3; i++) check($sformatf("wr_ptr%0d", i), stb_log[(s0 + i) % 64], 3 + i);
      check("wr_done_count", done_cnt - d0, 1);
      for (int i = 0; i < 3; i++) check_mem(3 + i, wd[i]);
      // random read with repeated START and pointer wrap
      d0 = done_cnt;
      start_cond;
      send_byte(8'hA0, 1'b0, a); check("rd_addr_ack", a, 0);
      send_byte(8'h0E, 1'b0, a); check("rd_ptr_ack", a, 0);
      start_cond;
      send_byte(8'hA1, 1'b0, a); check("rd_addr2_ack", a, 0);
      for (int i = 0; i < 3; i++) begin
         read_byte(d, i == 2);
         check($sformatf("rd_byte%0d", i), d, rd[i]);
      end
      stop_cond;
      check("rd_ack_err", ack_err, 0);
      check("rd_done_count", done_cnt - d0, 1);
      // address mismatch
      s0 = stb_cnt; d0 = done_cnt; o0 = oe_cnt;
      start_cond;
      send_byte(8'hB0, 1'b0, a); check("mis_addr_nack", a, 1);
      send_byte(8'h55, 1'b0, a); check("mis_data_nack", a, 1);
      check("mis_busy", busy, 1);
      stop_cond;
      check("mis_busy_clr", busy, 0);
      check("mis_oe_cycles", oe_cnt - o0, 0);
      check("mis_stb_count", stb_cnt - s0, 0);
      check("mis_done_count", done_cnt - d0, 0);
      // truncated write
      s0 = stb_cnt;
      start_cond;
      send_byte(8'hA0, 1'b0, a);
      send_byte(8'h02, 1'b0, a);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      stop_cond;
      check_mem(2, 8'h02);
      check("trunc_stb_count", stb_cnt - s0, 0);
      check("trunc_state", dut.state, IDLE);
      // truncated read sets ack_err, next START clears it
      start_cond;
      send_byte(8'hA0, 1'b0, a);
      send_byte(8'h09, 1'b0, a);
      send_byte(8'h80, 1'b0, a);
      stop_cond;
      start_cond;
      send_byte(8'hA0, 1'b0, a);
      send_byte(8'h08, 1'b0, a);
      start_cond;
      send_byte(8'hA1, 1'b0, a);
      read_byte(d, 1'b0);
      check("tr_byte", d, 8'h08);
      stop_cond;
      check("tr_ack_err", ack_err, 1);
      start_cond;
      check("tr_ack_err_clr", ack_err, 0);
      stop_cond;
      // async reset while the slave drives a read bit
      start_cond;
      send_byte(8'hA0, 1'b0, a);
      send_byte(8'h04, 1'b0, a);
      start_cond;
      send_byte(8'hA1, 1'b0, a);
      for (int i = 0; i < 3; i++) read_bit(a);
      sda_m = 1'b1; wait_q;
      check("rr_bit3_drive", sda_oe, 1);
      rst = 1'b1;
      #1 check("rr_async_oe", sda_oe, 0);
      check("rr_async_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0; scl = 1'b1; sda_m = 1'b1;
      wait_q;
      for (int i = 3; i < 6; i++) check_mem(i, 8'(i));
      check_mem(9, 8'h09);
      start_cond;
      send_byte(8'hA1, 1'b0, a); check("rr_addr_ack", a, 0);
      read_byte(d, 1'b1);
      check("rr_byte0", d, 8'h00);
      stop_cond;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
